keypad_scan: RTL and testbench



---
 rtl/keypad_scan.sv | 181 ++++++++++++++++++
 tb/tb_keypad_scan.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// keypad_scan
// Scans a 4x4 active-low key matrix one column at a time and debounces a
// single candidate key. Each accepted press is reported as a 4-bit key code
// (4*row + col) together with a one-cycle valid pulse and a held level.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous reset, active-high
//   row_n      in   4  matrix rows, pulled up, low = key closed in driven column
//   col_n      out  4  column drive, active-low, one bit low (col 0 = 4'b0111)
//   key_code   out  4  last accepted key, holds until the next accepted press
//   key_valid  out  1  one-cycle pulse when a press is accepted
//   key_down   out  1  high from press acceptance until release acceptance
module keypad_scan #(
  parameter int SCAN_DIV_BIT   = 14,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEB_PRESS,
    ST_HELD,
    ST_DEB_REL
  } state_t;

  localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_SCANS);

  logic [SCAN_DIV_BIT-1:0] r_presc;
  logic [1:0]              r_col;
  logic [3:0]              r_sync1;
  logic [3:0]              r_sync2;
  state_t                  r_state;
  logic [3:0]              r_cand;
  logic [3:0]              r_cnt;
  logic [3:0]              r_key_code;
  logic                    r_key_valid;
  logic                    r_key_down;

  logic       w_sample;
  logic       w_any_low;
  logic [1:0] w_row_idx;
  logic       w_at_cand_col;
  logic       w_cand_low;
  logic [3:0] w_cnt_inc;
  logic [3:0] w_col_n;

  // Prescaler and column index. The column advances on the last dwell cycle,
  // which is also the sample point for the column being left.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_col   <= '0;
    end else begin
      r_presc <= r_presc + SCAN_DIV_BIT'(1);
      if (w_sample) begin
        r_col <= r_col + 2'd1;
      end
    end
  end

  assign w_sample = &r_presc;

  // Column 0 drives bit 3 low, column 3 drives bit 0 low.
  for (genvar gi = 0; gi < 4; gi++) begin : g_col_dec
    assign w_col_n[gi] = (r_col != 2'(3 - gi));
  end
  assign col_n = w_col_n;

  // Two-stage synchronizer; idle level of the pulled-up rows is all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 4'b1111;
      r_sync2 <= 4'b1111;
    end else begin
      r_sync1 <= row_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_any_low = ~&r_sync2;

  // Lowest-index low row wins when several rows are closed.
  always_comb begin
    w_row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_sync2[i]) begin
        w_row_idx = 2'(i);
      end
    end
  end

  assign w_at_cand_col = (r_col == r_cand[1:0]);
  assign w_cand_low    = ~r_sync2[r_cand[3:2]];
  assign w_cnt_inc     = r_cnt + 4'd1;

  // Debounce FSM. Only sample points advance it; outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cand      <= 4'd0;
      r_cnt       <= 4'd0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_sample) begin
        case (r_state)
          ST_IDLE: begin
            if (w_any_low) begin
              r_cand <= {w_row_idx, r_col};
              r_cnt  <= 4'd1;
              if (DEB_LIMIT == 4'd1) begin
                r_key_code  <= {w_row_idx, r_col};
                r_key_valid <= 1'b1;
                r_key_down  <= 1'b1;
                r_state     <= ST_HELD;
              end else begin
                r_state <= ST_DEB_PRESS;
              end
            end
          end
          ST_DEB_PRESS: begin
            if (w_at_cand_col) begin
              if (w_cand_low) begin
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc == DEB_LIMIT) begin
                  r_key_code  <= r_cand;
                  r_key_valid <= 1'b1;
                  r_key_down  <= 1'b1;
                  r_state     <= ST_HELD;
                end
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
          ST_HELD: begin
            if (w_at_cand_col && !w_cand_low) begin
              r_cnt <= 4'd1;
              if (DEB_LIMIT == 4'd1) begin
                r_key_down <= 1'b0;
                r_state    <= ST_IDLE;
              end else begin
                r_state <= ST_DEB_REL;
              end
            end
          end
          ST_DEB_REL: begin
            if (w_at_cand_col) begin
              if (!w_cand_low) begin
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc == DEB_LIMIT) begin
                  r_key_down <= 1'b0;
                  r_state    <= ST_IDLE;
                end
              end else begin
                // Release bounced: key is still considered held.
                r_state <= ST_HELD;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;

  localparam int SDB = 2;
  localparam int D   = 4;
  localparam int S_IDLE = 0, S_DEBP = 1, S_HELD = 2, S_DEBR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mask = 16'h0000;   // bit 4*row+col set = key physically closed

  logic [3:0] row_n_a, col_n_a, code_a;
  logic       valid_a, down_a;
  logic [3:0] row_n_b, col_n_b, code_b;
  logic       valid_b, down_b;

  always #5 clk = ~clk;

  // Keypad model: a closed key pulls its row low while its column is driven.
  function automatic logic [3:0] rows_for(input logic [15:0] m, input logic [3:0] cn);
    int c;
    logic [3:0] r;
    r = 4'b1111;
    case (cn)
      4'b0111: c = 0;
      4'b1011: c = 1;
      4'b1101: c = 2;
      4'b1110: c = 3;
      default: c = -1;
    endcase
    if (c >= 0) begin
      for (int k = 0; k < 4; k++) r[k] = ~m[4*k + c];
    end
    return r;
  endfunction

  assign row_n_a = rows_for(mask, col_n_a);
  assign row_n_b = rows_for(mask, col_n_b);

  keypad_scan #(.SCAN_DIV_BIT(SDB), .DEBOUNCE_SCANS(4)) dut_a (
    .clk(clk), .rst(rst), .row_n(row_n_a), .col_n(col_n_a),
    .key_code(code_a), .key_valid(valid_a), .key_down(down_a)
  );

  keypad_scan #(.SCAN_DIV_BIT(SDB), .DEBOUNCE_SCANS(1)) dut_b (
    .clk(clk), .rst(rst), .row_n(row_n_b), .col_n(col_n_b),
    .key_code(code_b), .key_valid(valid_b), .key_down(down_b)
  );

  // ---------------- behavioural reference ----------------
  int  mn;                 // cycles since reset release
  bit  armed = 0;
  int  ds[2]      = '{4, 1};
  int  m_state[2] = '{S_IDLE, S_IDLE};
  int  m_cand[2]  = '{0, 0};
  int  m_cnt[2]   = '{0, 0};
  int  m_code[2]  = '{0, 0};
  bit  m_valid[2] = '{0, 0};
  bit  m_down[2]  = '{0, 0};
  logic [3:0] colpat[4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  task automatic accept(input int i);
    m_code[i]  = m_cand[i];
    m_valid[i] = 1;
    m_down[i]  = 1;
    m_state[i] = S_HELD;
  endtask

  // One sample of column c: what the scanner sees is simply which keys of
  // that column are closed.
  task automatic model_sample(input int i, input int c);
    int  low_row;
    bit  cand_closed;
    low_row = -1;
    for (int rr = 3; rr >= 0; rr--) if (mask[4*rr + c]) low_row = rr;
    cand_closed = mask[m_cand[i]];
    case (m_state[i])
      S_IDLE: if (low_row >= 0) begin
        m_cand[i] = 4*low_row + c;
        m_cnt[i]  = 1;
        if (ds[i] == 1) accept(i); else m_state[i] = S_DEBP;
      end
      S_DEBP: if (c == m_cand[i] % 4) begin
        if (cand_closed) begin
          m_cnt[i]++;
          if (m_cnt[i] == ds[i]) accept(i);
        end else m_state[i] = S_IDLE;
      end
      S_HELD: if (c == m_cand[i] % 4 && !cand_closed) begin
        m_cnt[i] = 1;
        if (ds[i] == 1) begin m_down[i] = 0; m_state[i] = S_IDLE; end
        else m_state[i] = S_DEBR;
      end
      default: if (c == m_cand[i] % 4) begin
        if (!cand_closed) begin
          m_cnt[i]++;
          if (m_cnt[i] == ds[i]) begin m_down[i] = 0; m_state[i] = S_IDLE; end
        end else m_state[i] = S_HELD;
      end
    endcase
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) m_valid[i] = 0;
    if (rst) begin
      armed = 1;
      mn = 0;
      for (int i = 0; i < 2; i++) begin
        m_state[i] = S_IDLE; m_cand[i] = 0; m_cnt[i] = 0;
        m_code[i] = 0; m_down[i] = 0;
      end
    end else begin
      if (mn % D == D - 1) begin
        for (int i = 0; i < 2; i++) model_sample(i, (mn / D) % 4);
      end
      mn++;
    end
  end

  // ---------------- checking ----------------
  int n_total = 0;
  int n_pass  = 0;
  int pulses_a = 0, pulses_b = 0;
  int last_pulse_a = -1, last_pulse_b = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d (cycle %0d, t=%0t)", name, act, exp, mn, $time);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("colA",   int'(col_n_a), int'(colpat[(mn / D) % 4]));
      chk("codeA",  int'(code_a),  m_code[0]);
      chk("validA", int'(valid_a), int'(m_valid[0]));
      chk("downA",  int'(down_a),  int'(m_down[0]));
      chk("colB",   int'(col_n_b), int'(colpat[(mn / D) % 4]));
      chk("codeB",  int'(code_b),  m_code[1]);
      chk("validB", int'(valid_b), int'(m_valid[1]));
      chk("downB",  int'(down_b),  int'(m_down[1]));
      if (valid_a === 1'b1) begin pulses_a++; last_pulse_a = mn; end
      if (valid_b === 1'b1) begin pulses_b++; last_pulse_b = mn; end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Leaves the caller at the negedge of cycle 0 after release.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    pulses_a = 0; pulses_b = 0;
    last_pulse_a = -1; last_pulse_b = -1;
  endtask

  task automatic wait_until(input int n);
    int guard;
    guard = 0;
    while (mn < n && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (mn < n) chk("wait_timeout", mn, n);
  endtask

  // Key changes land at the start of a column dwell so they are settled
  // well ahead of the next sample point.
  task automatic set_mask(input logic [15:0] m);
    int guard;
    guard = 0;
    while (mn % D != 0 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    mask = m;
  endtask

  logic [3:0] exp_cols[5] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b0111};
  logic [15:0] rm;
  int sel;

  initial begin
    // Reset state and column walk.
    mask = 16'h0000;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_col",   int'(col_n_a), 7);
    chk("rst_code",  int'(code_a),  0);
    chk("rst_valid", int'(valid_a), 0);
    chk("rst_down",  int'(down_a),  0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("walk_col", int'(col_n_a), int'(exp_cols[k]));
      repeat (4) @(negedge clk);
    end

    // Clean press of key 9 (row 2, col 1) then 10 more scans.
    mask = 16'h0200;
    do_reset(3);
    repeat (216) @(negedge clk);
    chk("press_pulses", pulses_a, 1);
    chk("press_time",   last_pulse_a, 56);
    chk("press_code",   int'(code_a), 9);
    chk("press_down",   int'(down_a), 1);
    chk("press1_time",  last_pulse_b, 8);

    // Release: fourth high sample of col 1 is at cycle 279.
    set_mask(16'h0000);
    wait_until(279);
    chk("rel_down_before", int'(down_a), 1);
    @(negedge clk);
    chk("rel_down_after",  int'(down_a), 0);
    chk("rel_code",        int'(code_a), 9);

    // Release with a one-scan glitch keeps the key held.
    mask = 16'h0200;
    do_reset(3);
    wait_until(64);
    set_mask(16'h0000);
    wait_until(80);
    set_mask(16'h0200);
    wait_until(200);
    chk("glitch_down",   int'(down_a), 1);
    chk("glitch_pulses", pulses_a, 1);

    // Press bounce: two matching scans, then gone.
    mask = 16'h0200;
    do_reset(3);
    wait_until(32);
    set_mask(16'h0000);
    wait_until(150);
    chk("bounce_pulses", pulses_a, 0);
    chk("bounce_down",   int'(down_a), 0);
    chk("bounce_code",   int'(code_a), 0);

    // Priority: rows 1 and 3 on col 2 -> key 6; then key 3 ignored.
    mask = 16'h4040;
    do_reset(3);
    wait_until(64);
    chk("prio_code", int'(code_a), 6);
    set_mask(16'h4048);
    wait_until(200);
    chk("prio_pulses", pulses_a, 1);
    chk("prio_hold",   int'(code_a), 6);
    chk("prio_down",   int'(down_a), 1);

    // Reset after three matching scans discards the debounce.
    mask = 16'h0200;
    do_reset(3);
    wait_until(44);
    chk("mid_pulses", pulses_a, 0);
    do_reset(3);
    chk("mid_code",  int'(code_a), 0);
    chk("mid_down",  int'(down_a), 0);
    chk("mid_codeB", int'(code_b), 0);
    wait_until(70);
    chk("mid_repulse",  pulses_a, 1);
    chk("mid_time",     last_pulse_a, 56);
    chk("mid_time1",    last_pulse_b, 8);

    // Randomized key patterns and occasional resets against the model.
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        if (sel <= 2)      rm = 16'h0000;
        else if (sel <= 6) rm = 16'(1) << $urandom_range(0, 15);
        else               rm = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        set_mask(rm);
        repeat ($urandom_range(1, 6) * 16) @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
